// File: rtl/bu2020_ctrl_pkg.sv
// Shared types and constants for the BU2020 pipeline sequencer.
// Covers the sequencer state encoding, the EX operand-select codes and the bubble instruction.
package bu2020_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrl_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // addi x0, x0, 0 : what a flushed stage register carries (wen = 0)
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding comparator for the EX stage.
// The MEM-stage result is newer than the WB value, so it wins when both match.
module fwd_sel
    import bu2020_ctrl_pkg::*;
#(
    parameter int REG_AW = 3
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wen,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_wen,
    output logic [1:0]        sel
);

    always_comb begin
        sel = FWD_RF;
        if (rs != '0) begin
            if (mem_wen && (mem_rd == rs)) begin
                sel = FWD_MEM;
            end else if (wb_wen && (wb_rd == rs)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the five-stage BU2020 pipeline: stage enables, flushes,
// operand forwarding selects, data-memory wait/timeout handling and a stall counter.
//
// state    | meaning
// ---------+------------------------------------------------------------------
// RUN      | normal issue; load-use stalls and branch flushes resolved here
// MEM_WAIT | data memory access pending, whole pipeline frozen
// ERROR    | access exceeded MAX_WAIT cycles; frozen until reset
module pipeline_ctrl
    import bu2020_ctrl_pkg::*;
#(
    parameter int REG_AW   = 3,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_wen,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wen,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_wen,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_timeout,
    output logic [15:0]       stall_cycles
);

    localparam int CW = $clog2(MAX_WAIT);

    ctrl_state_t   state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [15:0]   stall_q, stall_d;

    logic hit_rs1, hit_rs2, load_use, mem_stall, issue;
    logic pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c;
    logic if_id_flush_c, id_ex_flush_c;
    logic [1:0] fwd_a_c, fwd_b_c;

    assign hit_rs1   = (id_rs1 != '0) && id_use_rs1 && ex_is_load && ex_wen && (ex_rd == id_rs1);
    assign hit_rs2   = (id_rs2 != '0) && id_use_rs2 && ex_is_load && ex_wen && (ex_rd == id_rs2);
    assign load_use  = hit_rs1 || hit_rs2;
    assign mem_stall = mem_req && !mem_ready;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        issue         = 1'b0;
        pc_en_c       = 1'b0;
        if_id_en_c    = 1'b0;
        id_ex_en_c    = 1'b0;
        ex_mem_en_c   = 1'b0;
        mem_wb_en_c   = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = CW'(1);
                end else begin
                    issue = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    issue      = 1'b1;
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == CW'(MAX_WAIT - 1)) begin
                    state_d = ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ERROR;
            end
        endcase

        // Branch squashes the ID instruction, so its load-use hazard is moot
        if (issue) begin
            ex_mem_en_c = 1'b1;
            mem_wb_en_c = 1'b1;
            id_ex_en_c  = 1'b1;
            if (ex_branch_taken) begin
                pc_en_c       = 1'b1;
                if_id_en_c    = 1'b1;
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
            end else if (load_use) begin
                id_ex_flush_c = 1'b1;
            end else begin
                pc_en_c    = 1'b1;
                if_id_en_c = 1'b1;
            end
        end
    end

    assign stall_d = (!pc_en_c && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
        end
    end

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs      (id_rs1),
        .mem_rd  (mem_rd),
        .mem_wen (mem_wen),
        .wb_rd   (wb_rd),
        .wb_wen  (wb_wen),
        .sel     (fwd_a_c)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs      (id_rs2),
        .mem_rd  (mem_rd),
        .mem_wen (mem_wen),
        .wb_rd   (wb_rd),
        .wb_wen  (wb_wen),
        .sel     (fwd_b_c)
    );

    // Gate every output with rst_n so nothing can pulse high while reset is held
    assign pc_en        = rst_n & pc_en_c;
    assign if_id_en     = rst_n & if_id_en_c;
    assign id_ex_en     = rst_n & id_ex_en_c;
    assign ex_mem_en    = rst_n & ex_mem_en_c;
    assign mem_wb_en    = rst_n & mem_wb_en_c;
    assign if_id_flush  = rst_n & if_id_flush_c;
    assign id_ex_flush  = rst_n & id_ex_flush_c;
    assign fwd_a        = rst_n ? fwd_a_c : FWD_RF;
    assign fwd_b        = rst_n ? fwd_b_c : FWD_RF;
    assign mem_timeout  = rst_n & (state_q == ERROR);
    assign stall_cycles = stall_q;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencer for the five-stage BU2020 pipeline (IF, ID, EX, MEM, WB). It gates every inter-stage register and the PC, and resolves three kinds of hazard:
- load-use data hazards, by stalling;
- taken branches, by flushing;
- slow data memory, by freezing the pipeline with a wait-state handshake and a timeout.

It also drives the EX-stage operand forwarding selects and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- REG_AW, 3: register index width; index 0 is hardwired zero and is never forwarded or hazard-checked.
- MAX_WAIT, 16: maximum MEM wait cycles before the error state; must be at least 2.

Ports:
- clk  in  1  rising-edge clock, shared with all stage registers.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  the ID instruction reads rs1 / rs2.
- ex_rd  in  REG_AW  destination register of the instruction in EX.
- ex_wen, ex_is_load  in  1  the EX instruction writes a register / is a load.
- mem_rd  in  REG_AW  destination register of the instruction in MEM.
- mem_wen  in  1  the MEM instruction writes a register.
- wb_rd  in  REG_AW  destination register of the instruction in WB.
- wb_wen  in  1  the WB instruction writes a register.
- ex_branch_taken  in  1  branch resolved taken in EX.
- mem_req  in  1  the MEM stage accesses data memory this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  load enables for the PC and each stage register.
- if_id_flush, id_ex_flush  out  1  load a bubble (NOP, wen=0) instead of the stage output.
- fwd_a, fwd_b  out  2  EX operand selects: 00 register file, 01 MEM-stage ALU result, 10 WB value.
- mem_timeout  out  1  sticky error flag.
- stall_cycles  out  16  count of cycles in which pc_en was 0; saturates at 0xFFFF.

## Operation
State machine: RUN, MEM_WAIT, ERROR. Reset enters RUN.

Signal definitions:
- hit(r) = (r != 0) && ID uses r && ex_is_load && ex_wen && ex_rd == r.
- load_use = hit(id_rs1) || hit(id_rs2).
- mem_stall = mem_req && !mem_ready.

RUN, checked in priority order:
1. If mem_stall:
   - all five enables = 0 and both flushes = 0;
   - next state MEM_WAIT; wait_cnt <= 1.
2. Else if ex_branch_taken:
   - all enables = 1;
   - if_id_flush = 1 and id_ex_flush = 1, i.e. two bubbles;
   - load_use is ignored because the ID instruction is squashed.
3. Else if load_use:
   - pc_en = 0, if_id_en = 0;
   - id_ex_en = 1 with id_ex_flush = 1;
   - ex_mem_en = 1, mem_wb_en = 1.
4. Else: all enables = 1 and no flush.

MEM_WAIT:
- If mem_ready: behave exactly as RUN rules 2–4 for this cycle, with the current inputs; next state RUN.
- Else if wait_cnt == MAX_WAIT - 1: next state ERROR.
- Else: enables = 0 and wait_cnt increments.

ERROR:
- All enables = 0 and mem_timeout = 1.
- Only rst_n leaves this state.

Forwarding, evaluated independently for operand a (id_rs1) and b (id_rs2) of the EX instruction:
- 01 if mem_wen && mem_rd == rs && rs != 0;
- else 10 if wb_wen && wb_rd == rs && rs != 0;
- else 00.
- MEM has priority over WB.
- Forwarding is combinational and is independent of state.

## Timing
- All enables and flushes are combinational from the current state and inputs; the stage registers sample them on the same rising edge.
- Load-use stall costs exactly 1 cycle. A taken branch costs 2 cycles. A memory access with mem_ready asserted in the request cycle costs 0 cycles.
- A MEM access of N wait cycles freezes the pipeline for N cycles. ERROR is entered on the edge after MAX_WAIT cycles with the access still pending.
- stall_cycles increments on each edge at which pc_en == 0, and holds at 0xFFFF.
- While rst_n is low:
  - all enables = 0, both flushes = 0, fwd_a = fwd_b = 00;
  - mem_timeout = 0, stall_cycles = 0, wait_cnt = 0, state = RUN.
- Asserting reset in MEM_WAIT or ERROR aborts immediately. No output glitches to 1 during reset.

## Structure
- Package bu2020_ctrl_pkg holds:
  - the state enum ctrl_state_t {RUN, MEM_WAIT, ERROR};
  - the forwarding constants FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10;
  - the NOP encoding for bubbles.
- One sub-module, fwd_sel, holds the per-operand comparator; pipeline_ctrl instantiates it twice.

## Test plan
- EX holds a load with ex_rd = 3 and ID reads r3: one cycle with pc_en = 0, if_id_en = 0, id_ex_flush = 1. The next cycle resumes with fwd_a = 10. stall_cycles = 1.
- ex_branch_taken = 1 together with load_use = 1: if_id_flush = 1, id_ex_flush = 1, pc_en = 1, stall_cycles unchanged.
- mem_req = 1 with mem_ready asserted 3 cycles late: enables are 0 for exactly 3 cycles and reassert in the ready cycle; stall_cycles = 3; state back to RUN.
- mem_req = 1 with mem_ready never asserted (MAX_WAIT = 16): ERROR after 16 cycles, mem_timeout = 1 and sticky. rst_n pulse clears it.
- mem_rd = wb_rd = 5 with both wen = 1, ID rs1 = 5, rs2 = 0: fwd_a = 01, fwd_b = 00. Also ex_rd = 0 load-use: no stall.
- rst_n asserted mid-MEM_WAIT: outputs go to reset values asynchronously; after release, state RUN and all enables = 1 with idle inputs.
